// File: rtl/seg_pkg.sv
// Shared constants for the segment scan controller: segment codes,
// the log-writer state encoding and the BCD-to-segment lookup.
package seg_pkg;

    // Segment bit order is {dp,a,b,c,d,e,f,g}, active high.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_MINUS = 8'h01;
    localparam logic [7:0] SEG_E     = 8'h4F;
    localparam logic [7:0] SEG_R     = 8'h05;
    localparam logic [7:0] SEG_O     = 8'h1D;

    localparam logic [7:0] SEG_D0 = 8'h7E;
    localparam logic [7:0] SEG_D1 = 8'h30;
    localparam logic [7:0] SEG_D2 = 8'h6D;
    localparam logic [7:0] SEG_D3 = 8'h79;
    localparam logic [7:0] SEG_D4 = 8'h33;
    localparam logic [7:0] SEG_D5 = 8'h5B;
    localparam logic [7:0] SEG_D6 = 8'h5F;
    localparam logic [7:0] SEG_D7 = 8'h70;
    localparam logic [7:0] SEG_D8 = 8'h7F;
    localparam logic [7:0] SEG_D9 = 8'h7B;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } seg_state_t;

    // Non-decimal nibbles map to blank; callers reject such frames anyway.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_D0;
            4'd1:    return SEG_D1;
            4'd2:    return SEG_D2;
            4'd3:    return SEG_D3;
            4'd4:    return SEG_D4;
            4'd5:    return SEG_D5;
            4'd6:    return SEG_D6;
            4'd7:    return SEG_D7;
            4'd8:    return SEG_D8;
            4'd9:    return SEG_D9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_log_fifo.sv
// Small synchronous FIFO that records every digit code written to the
// display. Pushes into a full FIFO are dropped and flagged stickily,
// unless a pop in the same cycle frees the slot.
module seg_log_fifo #(
    parameter int LOG_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       ovf
);

    localparam int AW = $clog2(LOG_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [LOG_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    dout_q;
    logic          ovf_q;

    logic full;
    logic do_pop;
    logic do_push;
    logic drop;

    assign full    = (count_q == CW'(LOG_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = dout_q;
    assign ovf     = ovf_q;

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy, registered read data and the overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display controller. Captures a signed BCD
// frame, converts it to segment codes (with error text and optional
// leading-zero blanking), scans the digits one at a time, and logs every
// frame's digit codes into a FIFO, least significant digit first.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 5,
    parameter int SCAN_DIV  = 1000,
    parameter int LOG_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4*NDIG:0] bcd_in,
    input  logic            load,
    input  logic            blank_lz,
    output logic [7:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            err,
    output logic            busy,
    input  logic            log_rd,
    output logic [7:0]      log_dout,
    output logic            log_empty,
    output logic            log_ovf
);

    localparam int IDX_W = $clog2(NDIG);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [NDIG-1:0] AN_FIRST = {{(NDIG-1){1'b0}}, 1'b1};

    seg_state_t       state_q;
    seg_state_t       state_d;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] wr_idx_d;

    logic [7:0]       dig_q   [NDIG];
    logic [7:0]       dig_new [NDIG];
    logic             err_q;
    logic             frame_ok;
    logic             lead;
    logic             accept;

    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] scan_idx_q;
    logic [7:0]       seg_q;
    logic [NDIG-1:0]  an_q;

    logic             push;
    logic [7:0]       push_data;

    assign accept    = load && (state_q == ST_IDLE);
    assign busy      = (state_q == ST_WRITE);
    assign err       = err_q;
    assign seg       = seg_q;
    assign an        = an_q;
    assign push_data = dig_q[wr_idx_q];

    // Decode the incoming frame into the digit codes it would display.
    always_comb begin
        frame_ok = 1'b1;
        lead     = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            dig_new[i] = SEG_BLANK;
        end
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                frame_ok = 1'b0;
            end
        end
        // A sign needs the top digit position free for the minus glyph.
        if (bcd_in[4*NDIG] && (bcd_in[4*(NDIG-1) +: 4] != 4'd0)) begin
            frame_ok = 1'b0;
        end
        // Walk down from the MSD; digits stay blankable until a non-zero.
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (bcd_in[4*i +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (blank_lz && lead && (i != 0)) begin
                dig_new[i] = SEG_BLANK;
            end else begin
                dig_new[i] = bcd_to_seg(bcd_in[4*i +: 4]);
            end
        end
        if (bcd_in[4*NDIG]) begin
            dig_new[NDIG-1] = SEG_MINUS;
        end
        if (!frame_ok) begin
            for (int i = 0; i < NDIG; i++) begin
                dig_new[i] = SEG_BLANK;
            end
            dig_new[0] = SEG_E;
            dig_new[1] = SEG_R;
            dig_new[2] = SEG_R;
            dig_new[3] = SEG_O;
            dig_new[4] = SEG_R;
        end
    end

    // Digit registers and error flag change only on an accepted load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NDIG; i++) begin
                dig_q[i] <= SEG_BLANK;
            end
            err_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < NDIG; i++) begin
                dig_q[i] <= dig_new[i];
            end
            err_q <= ~frame_ok;
        end
    end

    // Scan divider and current digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= '0;
            scan_idx_q <= '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q      <= '0;
            scan_idx_q <= (scan_idx_q == IDX_W'(NDIG - 1)) ? '0 : scan_idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Registered segment and anode drive for the digit being scanned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_FIRST;
        end else begin
            seg_q <= dig_q[scan_idx_q];
            an_q  <= AN_FIRST << scan_idx_q;
        end
    end

    // Log-writer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    // Log-writer next state: one digit pushed per WRITE cycle, LSD first.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_WRITE;
                    wr_idx_d = '0;
                end
            end
            ST_WRITE: begin
                push = 1'b1;
                if (wr_idx_q == IDX_W'(NDIG - 1)) begin
                    state_d  = ST_IDLE;
                    wr_idx_d = '0;
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_idx_d = '0;
            end
        endcase
    end

    seg_log_fifo #(
        .LOG_DEPTH(LOG_DEPTH)
    ) u_log (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (push_data),
        .pop  (log_rd),
        .dout (log_dout),
        .empty(log_empty),
        .ovf  (log_ovf)
    );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: behavioural model compared every cycle, plus
// directed frames with literal expected digit codes and randomized traffic.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 5;
    localparam int SD    = 4;
    localparam int DEPTH = 8;
    localparam int BW    = 4 * NDIG + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BW-1:0]   bcd_in = '0;
    logic            load = 1'b0;
    logic            blank_lz = 1'b0;
    logic            log_rd = 1'b0;
    logic [7:0]      seg;
    logic [NDIG-1:0] an;
    logic            err;
    logic            busy;
    logic [7:0]      log_dout;
    logic            log_empty;
    logic            log_ovf;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bit [7:0] CODE [10] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                            8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};
    bit [7:0] ERRC [5]  = '{8'h4F, 8'h05, 8'h05, 8'h1D, 8'h05};

    // model state
    int              n;
    logic [7:0]      m_dig [NDIG];
    logic            m_err;
    int              busy_left;
    logic [7:0]      q [$];
    logic [7:0]      exp_dout;
    logic            m_ovf;
    logic [7:0]      exp_seg;
    logic [NDIG-1:0] exp_an;

    seg_scan_ctrl #(
        .NDIG(NDIG), .SCAN_DIV(SD), .LOG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .an(an), .err(err), .busy(busy),
        .log_rd(log_rd), .log_dout(log_dout), .log_empty(log_empty),
        .log_ovf(log_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        n = 0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 8'h00;
        m_err = 1'b0;
        busy_left = 0;
        q.delete();
        exp_dout = 8'h00;
        m_ovf = 1'b0;
        exp_seg = 8'h00;
        exp_an = NDIG'(1);
    endtask

    task automatic m_frame();
        int nib [NDIG];
        int top;
        bit ok;
        bit sg;
        sg  = bcd_in[BW-1];
        ok  = 1'b1;
        top = 0;
        for (int i = 0; i < NDIG; i++) begin
            nib[i] = int'(bcd_in[4*i +: 4]);
            if (nib[i] > 9) ok = 1'b0;
            if (nib[i] != 0) top = i;
        end
        if (sg && nib[NDIG-1] != 0) ok = 1'b0;
        if (ok) begin
            for (int i = 0; i < NDIG; i++)
                m_dig[i] = (blank_lz && i > top) ? 8'h00 : CODE[nib[i]];
            if (sg) m_dig[NDIG-1] = 8'h01;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < NDIG; i++)
                m_dig[i] = (i < 5) ? ERRC[i] : 8'h00;
            m_err = 1'b1;
        end
    endtask

    task automatic m_step();
        int  pre_idx;
        bit  popped;
        pre_idx = (n / SD) % NDIG;
        exp_an  = NDIG'(1 << pre_idx);
        exp_seg = m_dig[pre_idx];
        n++;
        popped = 1'b0;
        if (log_rd && q.size() > 0) begin
            exp_dout = q.pop_front();
            popped = 1'b1;
        end
        if (busy_left > 0) begin
            if (q.size() < DEPTH) q.push_back(m_dig[NDIG - busy_left]);
            else m_ovf = 1'b1;
            busy_left--;
        end else if (load) begin
            m_frame();
            busy_left = NDIG;
        end
    endtask

    // model advances on each clock edge and resets with the DUT
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    // compare every output against the model mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("seg", seg, exp_seg);
                chk("an", an, exp_an);
                chk("err", err, m_err);
                chk("busy", busy, busy_left > 0);
                chk("log_dout", log_dout, exp_dout);
                chk("log_empty", log_empty, q.size() == 0);
                chk("log_ovf", log_ovf, m_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [BW-1:0] b, input logic blz);
        bcd_in   = b;
        blank_lz = blz;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
        @(negedge clk);
        chk(name, log_dout, exp);
    endtask

    task automatic seg_at(input logic [NDIG-1:0] target, input logic [7:0] exp);
        int k;
        k = 0;
        @(negedge clk);
        while (an !== target && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("an_reach", an, target);
        chk("seg_at_an", seg, exp);
    endtask

    task automatic rand_frame(output logic [BW-1:0] b);
        int z;
        b = '0;
        z = $urandom_range(0, NDIG - 1);
        for (int i = 0; i < NDIG; i++) begin
            int v;
            v = ($urandom % 10 == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            if (i >= NDIG - z) v = 0;
            b[4*i +: 4] = 4'(v);
        end
        b[BW-1] = 1'($urandom % 2);
    endtask

    initial begin
        logic [BW-1:0] rb;

        // reset values
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", seg, 8'h00);
        chk("rst_an", an, 5'b00001);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", log_empty, 1'b1);
        chk("rst_ovf", log_ovf, 1'b0);
        chk("rst_dout", log_dout, 8'h00);
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // plain frame 12345
        do_load(21'h012345, 1'b0);
        wait_idle();
        pop_check("f1_d0", 8'h5B);
        pop_check("f1_d1", 8'h33);
        pop_check("f1_d2", 8'h79);
        pop_check("f1_d3", 8'h6D);
        pop_check("f1_d4", 8'h30);
        chk("f1_empty", log_empty, 1'b1);
        seg_at(5'b00001, 8'h5B);
        seg_at(5'b00100, 8'h79);
        seg_at(5'b10000, 8'h30);
        tick();

        // negative with leading-zero blanking
        do_load(21'h100042, 1'b1);
        wait_idle();
        chk("f2_err", err, 1'b0);
        pop_check("f2_d0", 8'h6D);
        pop_check("f2_d1", 8'h33);
        pop_check("f2_d2", 8'h00);
        pop_check("f2_d3", 8'h00);
        pop_check("f2_d4", 8'h01);
        seg_at(5'b10000, 8'h01);
        tick();

        // invalid nibble
        do_load(21'h01A345, 1'b0);
        wait_idle();
        chk("f3_err", err, 1'b1);
        pop_check("f3_d0", 8'h4F);
        pop_check("f3_d1", 8'h05);
        pop_check("f3_d2", 8'h05);
        pop_check("f3_d3", 8'h1D);
        pop_check("f3_d4", 8'h05);
        tick();

        // overflow: two frames, one ignored load while busy
        do_load(21'h012345, 1'b0);
        tick();
        do_load(21'h077777, 1'b0);
        wait_idle();
        do_load(21'h099999, 1'b0);
        wait_idle();
        chk("ovf_set", log_ovf, 1'b1);
        pop_check("ov_0", 8'h5B);
        pop_check("ov_1", 8'h33);
        pop_check("ov_2", 8'h79);
        pop_check("ov_3", 8'h6D);
        pop_check("ov_4", 8'h30);
        pop_check("ov_5", 8'h7B);
        pop_check("ov_6", 8'h7B);
        pop_check("ov_7", 8'h7B);
        chk("ov_empty", log_empty, 1'b1);
        chk("ov_sticky", log_ovf, 1'b1);
        tick();

        // reset in the middle of a log write
        do_load(21'h012345, 1'b0);
        tick();
        #1 rst = 1'b0;
        #1;
        chk("mid_seg", seg, 8'h00);
        chk("mid_an", an, 5'b00001);
        chk("mid_err", err, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_empty", log_empty, 1'b1);
        chk("mid_ovf", log_ovf, 1'b0);
        chk("mid_dout", log_dout, 8'h00);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rand_frame(rb);
            bcd_in   = rb;
            blank_lz = 1'($urandom % 2);
            load     = ($urandom % 5 == 0);
            log_rd   = ($urandom % 3 == 0);
            tick();
        end
        load   = 1'b0;
        log_rd = 1'b0;
        repeat (3) tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 5, number of digits; legal range 5..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clk cycles per digit scan slot; minimum 2.
REQ-003 SHALL have parameter LOG_DEPTH, default 8, log FIFO entries; power of 2, minimum 2.
REQ-004 SHALL have ports, in this order:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bcd_in  in  4*NDIG+1  NDIG BCD nibbles (nibble 0 = LSD); MSB = sign.
- load  in  1  capture strobe for bcd_in.
- blank_lz  in  1  leading-zero blanking enable.
- seg  out  8  segment code {dp,a,b,c,d,e,f,g}, active high.
- an  out  NDIG  one-hot digit select, active high.
- err  out  1  last accepted frame was invalid.
- busy  out  1  log write in progress.
- log_rd  in  1  FIFO pop.
- log_dout  out  8  FIFO read data.
- log_empty  out  1  FIFO empty.
- log_ovf  out  1  sticky FIFO overflow.

Function
REQ-005 SHALL sample bcd_in when load=1 and busy=0; load while busy=1 SHALL be ignored.
REQ-006 Frame valid SHALL mean all nibbles <10 and, if sign=1, nibble NDIG-1 ==0.
REQ-007 Valid frame SHALL update digit registers 1 cycle after load: digit i = code(nibble i); if sign=1, digit NDIG-1 = minus (8'b00000001); err<=0.
REQ-008 Invalid frame SHALL set err<=1 and digits 0..4 = E,r,r,o,r (8'h4F,8'h05,8'h05,8'h1D,8'h05), digits 5..NDIG-1 = 8'h00.
REQ-009 With blank_lz=1 on a valid frame, zero digits above the most significant non-zero digit SHALL be 8'h00; digit 0 never blanked; minus retained.
REQ-010 Scan: divider counts 0..SCAN_DIV-1; on wrap, digit index advances, wrapping NDIG-1 -> 0.
REQ-011 an SHALL be one-hot at the current index; seg SHALL be that digit's register, both registered.
REQ-012 FSM states IDLE, WRITE; IDLE->WRITE on any accepted load (valid or invalid); WRITE lasts exactly NDIG cycles, then returns to IDLE.
REQ-013 In WRITE, one digit code per cycle SHALL be pushed, digit 0 first; busy=1 throughout WRITE.
REQ-014 Push when full SHALL be dropped and set log_ovf=1, which stays set until reset.
REQ-015 log_rd with log_empty=0 SHALL present the head entry on log_dout the next cycle; pop when empty SHALL be ignored, log_dout held.
REQ-016 Simultaneous push and pop SHALL both succeed, including when full; occupancy unchanged.
REQ-017 Pointers SHALL wrap modulo LOG_DEPTH; occupancy counter width clog2(LOG_DEPTH)+1.

Reset
REQ-018 On rst=0, asynchronously: seg=0, an=1 (digit 0), digit registers 0, err=0, busy=0, state IDLE, divider/index 0, FIFO pointers 0, log_empty=1, log_dout=0, log_ovf=0.
REQ-019 Reset during WRITE SHALL abort the sequence and discard FIFO contents.

Structure
REQ-020 Package seg_pkg SHALL hold the digit codes 0-9 (8'h7E,30,6D,79,33,5B,5F,70,7F,7B), E/r/o/minus/blank constants, the state enum and a BCD-to-code function.
REQ-021 FIFO SHALL be one sub-module, seg_log_fifo, parameterised by LOG_DEPTH.

Verification
REQ-022 NDIG=5, SCAN_DIV=4: load bcd_in=0_12345 -> digits 0..4 = 5B,33,79,6D,30; an steps 00001->...->10000 every 4 cycles, then wraps.
REQ-023 Load 1_00042, blank_lz=1 -> digits = 6D,33,00,00,01; err=0.
REQ-024 Load 0_1A345 -> err=1, digits E,r,r,o,r; 5 log entries 4F,05,05,1D,05.
REQ-025 LOG_DEPTH=8, two accepted loads with no pops -> 8 entries stored, log_ovf=1; second load during busy ignored.
REQ-026 Assert rst=0 mid-WRITE -> all outputs at reset values, log_empty=1 immediately.
